// File: rtl/clk_period_meas.sv
// Measures the half-period of a slow asynchronous square wave in clk cycles,
// reported as half-period minus one, with lock and timeout indication.
module clk_period_meas #(
   parameter int LOCK_N = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        sclk_in,
   output logic [15:0] half_cnt,
   output logic        cnt_valid,
   output logic        locked,
   output logic        timeout
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_FIRST,
      MEASURE
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        sync1;
   logic        sync2;
   logic        hist;
   logic        sclk_edge;
   logic [15:0] count;
   logic [15:0] count_nxt;
   logic [15:0] half_nxt;
   logic        valid_nxt;
   logic        locked_nxt;
   logic        timeout_nxt;
   logic [3:0]  match;
   logic [3:0]  match_nxt;

   // Two synchronizer stages, then a history flop so both edge polarities count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         hist  <= 1'b0;
      end else begin
         sync1 <= sclk_in;
         sync2 <= sync1;
         hist  <= sync2;
      end
   end

   assign sclk_edge = sync2 ^ hist;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         count     <= 16'd0;
         half_cnt  <= 16'd0;
         cnt_valid <= 1'b0;
         locked    <= 1'b0;
         timeout   <= 1'b0;
         match     <= 4'd0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         half_cnt  <= half_nxt;
         cnt_valid <= valid_nxt;
         locked    <= locked_nxt;
         timeout   <= timeout_nxt;
         match     <= match_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      count_nxt   = count;
      half_nxt    = half_cnt;
      valid_nxt   = 1'b0;
      locked_nxt  = locked;
      timeout_nxt = timeout;
      match_nxt   = match;
      if (!en) begin
         state_nxt   = IDLE;
         count_nxt   = 16'd0;
         locked_nxt  = 1'b0;
         timeout_nxt = 1'b0;
         match_nxt   = 4'd0;
      end else begin
         case (state)
            IDLE: begin
               state_nxt = WAIT_FIRST;
            end
            WAIT_FIRST: begin
               if (sclk_edge) begin
                  count_nxt   = 16'd0;
                  timeout_nxt = 1'b0;
                  state_nxt   = MEASURE;
               end
            end
            MEASURE: begin
               // An edge arriving with the counter at 16'hFFFF still counts as a measurement.
               if (sclk_edge) begin
                  half_nxt    = count;
                  count_nxt   = 16'd0;
                  valid_nxt   = 1'b1;
                  timeout_nxt = 1'b0;
                  if (count == half_cnt) begin
                     if (match < 4'(LOCK_N)) begin
                        match_nxt = match + 4'd1;
                     end
                  end else begin
                     match_nxt = 4'd1;
                  end
                  locked_nxt = (match_nxt == 4'(LOCK_N));
               end else if (count == 16'hFFFF) begin
                  timeout_nxt = 1'b1;
                  locked_nxt  = 1'b0;
                  match_nxt   = 4'd0;
                  state_nxt   = WAIT_FIRST;
               end else begin
                  count_nxt = count + 16'd1;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule
